// File: rtl/gelato_arb_grant_stage.sv
// Grant stage behind a round-robin arbiter: moves one beat per cycle from the selected port into a
// 2-entry tagged output buffer, with per-port starvation watchdogs.
module gelato_arb_grant_stage #(
    parameter int PORT_NUM_WIDTH = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 16,
    parameter int CNT_WIDTH      = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [PORT_NUM_WIDTH-1:0]                  selected,
    input  logic [(1<<PORT_NUM_WIDTH)-1:0]             in_valid,
    input  logic [(1<<PORT_NUM_WIDTH)*DATA_WIDTH-1:0]  in_data,
    output logic [(1<<PORT_NUM_WIDTH)-1:0]             in_ready,
    output logic                                       out_valid,
    output logic [DATA_WIDTH-1:0]                      out_data,
    output logic [PORT_NUM_WIDTH-1:0]                  out_port,
    input  logic                                       out_ready,
    output logic [(1<<PORT_NUM_WIDTH)-1:0]             starve
);

    localparam int NPORT = 1 << PORT_NUM_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LIMIT_C = CNT_WIDTH'(STARVE_LIMIT);

    logic [1:0]                count_r;
    logic                      wr_ptr_r;
    logic                      rd_ptr_r;
    logic [DATA_WIDTH-1:0]     data_mem_r [2];
    logic [PORT_NUM_WIDTH-1:0] port_mem_r [2];
    logic [CNT_WIDTH-1:0]      starve_cnt_r [NPORT];
    logic [NPORT-1:0]          starve_r;

    logic                      not_full_s;
    logic [NPORT-1:0]          port_accept_s;
    logic                      accept_s;
    logic                      pop_s;
    logic [DATA_WIDTH-1:0]     sel_data_s;
    logic [1:0]                count_next_s;
    logic [CNT_WIDTH-1:0]      cnt_next_s [NPORT];

    // Grant decode: only registered count and the arbiter's registered index feed in_ready.
    always_comb begin
        not_full_s = (count_r != 2'd2);
        in_ready   = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (selected == PORT_NUM_WIDTH'(p)) begin
                in_ready[p] = not_full_s;
            end else begin
                in_ready[p] = 1'b0;
            end
        end
        port_accept_s = in_valid & in_ready;
        accept_s      = |port_accept_s;
        pop_s         = (count_r != 2'd0) && out_ready;
        sel_data_s    = in_data[int'(selected)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Buffer occupancy: simultaneous accept and pop leave the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({accept_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Starvation counters clear on idle or service, otherwise climb and saturate at the limit.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            cnt_next_s[p] = starve_cnt_r[p];
            if (!in_valid[p] || port_accept_s[p]) begin
                cnt_next_s[p] = '0;
            end else if (starve_cnt_r[p] < LIMIT_C) begin
                cnt_next_s[p] = starve_cnt_r[p] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_next_s[p] = LIMIT_C;
            end
        end
    end

    // Buffer pointers, storage and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r       <= 2'd0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            data_mem_r[0] <= '0;
            data_mem_r[1] <= '0;
            port_mem_r[0] <= '0;
            port_mem_r[1] <= '0;
        end else begin
            count_r <= count_next_s;
            if (accept_s) begin
                data_mem_r[wr_ptr_r] <= sel_data_s;
                port_mem_r[wr_ptr_r] <= selected;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

    // Watchdog state; the flag is registered from the next count so it tracks the counter exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NPORT; p++) begin
                starve_cnt_r[p] <= '0;
            end
            starve_r <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                starve_cnt_r[p] <= cnt_next_s[p];
                starve_r[p]     <= (cnt_next_s[p] == LIMIT_C);
            end
        end
    end

    assign out_valid = (count_r != 2'd0);
    assign out_data  = data_mem_r[rd_ptr_r];
    assign out_port  = port_mem_r[rd_ptr_r];
    assign starve    = starve_r;

endmodule
